// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, constants and types for the register file scoreboard
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  pend_cnt_t;

  localparam pend_cnt_t CNT_MAX  = '1;
  localparam reg_idx_t  REG_ZERO = '0;

endpackage

// File: rtl/pending_counter.sv
// rtl/pending_counter.sv - saturating pending-write counter with inc, dec and clear
module pending_counter
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inc,
  input  logic      dec,
  input  logic      clr,
  output pend_cnt_t cnt
);

  // A decrement request at zero is not a real decrement, so it cannot cancel an increment.
  logic dec_ok;
  assign dec_ok = dec && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && !dec_ok && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end else if (dec_ok && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32x32 register file with per-register pending-write scoreboard
// Optional REGFILE_BYPASS_EN: same-cycle writeback forwarding to both read ports.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              issue_valid,
  input  logic              issue_uses_rs,
  input  logic              issue_uses_rt,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              stall,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush
);

  reg_data_t                  regs [NUM_REGS];
  pend_cnt_t [NUM_REGS-1:0]   cnt;
  logic                       haz_a, haz_b, full, fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != REG_ZERO)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = (rs_addr == REG_ZERO) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == REG_ZERO) ? '0 : regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_en && (wb_addr == rs_addr) && (rs_addr != REG_ZERO)) rs_data = wb_data;
    if (wb_en && (wb_addr == rt_addr) && (rt_addr != REG_ZERO)) rt_data = wb_data;
`endif
  end

  always_comb begin
    haz_a = issue_uses_rs && (rs_addr != REG_ZERO) && (cnt[rs_addr] != '0);
    haz_b = issue_uses_rt && (rt_addr != REG_ZERO) && (cnt[rt_addr] != '0);
`ifdef REGFILE_BYPASS_EN
    // The last outstanding write landing this cycle is forwarded, so it no longer blocks.
    if (wb_en && (wb_addr == rs_addr) && (cnt[rs_addr] == pend_cnt_t'(1))) haz_a = 1'b0;
    if (wb_en && (wb_addr == rt_addr) && (cnt[rt_addr] == pend_cnt_t'(1))) haz_b = 1'b0;
`endif
    full  = (issue_dst != REG_ZERO) && (cnt[issue_dst] == CNT_MAX);
    stall = issue_valid && (haz_a || haz_b || full);
    fire  = issue_valid && !stall;
  end

  assign cnt[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    pending_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (fire && (issue_dst == reg_idx_t'(i))),
      .dec   (wb_en && (wb_addr == reg_idx_t'(i))),
      .clr   (flush),
      .cnt   (cnt[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, issue_dst, wb_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        issue_valid, issue_uses_rs, issue_uses_rt, stall, wb_en, flush;

  typedef struct {
    string       name;
    logic        stall;
    logic        chk_rs;
    logic [31:0] rs;
    logic        chk_rt;
    logic [31:0] rt;
  } exp_t;

  exp_t        sb[$];
  logic        sample_req = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .issue_valid   (issue_valid),
    .issue_uses_rs (issue_uses_rs),
    .issue_uses_rt (issue_uses_rt),
    .issue_dst     (issue_dst),
    .stall         (stall),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .flush         (flush)
  );

  // Monitor: checks combinational outputs mid-cycle whenever a sample is requested.
  always @(negedge clk) begin
    if (sample_req) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL monitor: sample requested but scoreboard empty");
      end else begin
        exp_t e;
        e = sb.pop_front();
        total++;
        if (stall !== e.stall) begin
          bad++;
          $display("FAIL %s stall: got %b want %b", e.name, stall, e.stall);
        end
        if (e.chk_rs) begin
          total++;
          if (rs_data !== e.rs) begin
            bad++;
            $display("FAIL %s rs_data: got %h want %h", e.name, rs_data, e.rs);
          end
        end
        if (e.chk_rt) begin
          total++;
          if (rt_data !== e.rt) begin
            bad++;
            $display("FAIL %s rt_data: got %h want %h", e.name, rt_data, e.rt);
          end
        end
      end
    end
  end

  task automatic idle();
    issue_valid = 0; issue_uses_rs = 0; issue_uses_rt = 0; issue_dst = 0;
    rs_addr = 0; rt_addr = 0; wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0;
  endtask

  task automatic issue(input logic ur, input logic [4:0] rs, input logic ut,
                       input logic [4:0] rt, input logic [4:0] dst);
    issue_valid = 1; issue_uses_rs = ur; rs_addr = rs;
    issue_uses_rt = ut; rt_addr = rt; issue_dst = dst;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic expect_out(input string name, input logic st,
                            input logic crs, input logic [31:0] rs,
                            input logic crt, input logic [31:0] rt);
    exp_t e;
    e.name = name; e.stall = st; e.chk_rs = crs; e.rs = rs; e.chk_rt = crt; e.rt = rt;
    sb.push_back(e);
    sample_req = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample_req = 0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;

    // 1: every index reads zero after reset
    for (int i = 0; i < 32; i++) begin
      issue(1, 5'(i), 1, 5'(31 - i), 0);
      expect_out("reset_read", 0, 1, 32'h0, 1, 32'h0);
      step();
    end

    // 2: writes to $0 are dropped and never counted
    wb(0, 32'hDEADBEEF);
    issue(0, 0, 0, 0, 0);
    expect_out("wb_zero_cycle", 0, 1, 32'h0, 0, 0);
    step();
    issue(1, 0, 1, 0, 0);
    expect_out("read_zero", 0, 1, 32'h0, 1, 32'h0);
    step();

    // 3: RAW hazard on $8 and its release by writeback
    issue(0, 0, 0, 0, 8);
    expect_out("issue_dst8", 0, 0, 0, 0, 0);
    step();
    issue(1, 8, 0, 0, 0);
    expect_out("raw_rs8", 1, 0, 0, 0, 0);
    step();
    wb(8, 32'h12345678);
    expect_out("wb8_idle", 0, 0, 0, 0, 0);
    step();
    issue(1, 8, 0, 0, 0);
    expect_out("after_wb8", 0, 1, 32'h12345678, 0, 0);
    step();

    // 4: counter for $5 saturates at 3 pending writes
    for (int k = 0; k < 3; k++) begin
      issue(0, 0, 0, 0, 5);
      expect_out("fill5", 0, 0, 0, 0, 0);
      step();
    end
    issue(0, 0, 0, 0, 5);
    expect_out("full5", 1, 0, 0, 0, 0);
    step();
    issue(0, 0, 0, 0, 5);
    wb(5, 32'h55);
    expect_out("full5_wb", 1, 0, 0, 0, 0);
    step();
    issue(0, 0, 0, 0, 5);
    expect_out("full5_retry", 0, 0, 0, 0, 0);
    step();

    // 5: simultaneous inc/dec holds, then flush clears
    issue(0, 0, 0, 0, 9);
    expect_out("issue9_a", 0, 0, 0, 0, 0);
    step();
    issue(0, 0, 0, 0, 9);
    wb(9, 32'h99);
    expect_out("issue9_wb9", 0, 0, 0, 0, 0);
    step();
    issue(0, 0, 0, 0, 9);
    expect_out("issue9_b", 0, 0, 0, 0, 0);
    step();
    issue(0, 0, 0, 0, 9);
    expect_out("issue9_c", 0, 0, 0, 0, 0);
    step();
    issue(0, 0, 0, 0, 9);
    expect_out("full9", 1, 0, 0, 0, 0);
    step();
    issue(1, 9, 0, 0, 0);
    expect_out("raw9_preflush", 1, 1, 32'h99, 0, 0);
    step();
    issue(0, 0, 0, 0, 10);
    flush = 1;
    expect_out("flush_fire10", 0, 0, 0, 0, 0);
    step();
    issue(1, 9, 1, 10, 0);
    expect_out("post_flush", 0, 1, 32'h99, 1, 32'h0);
    step();
    issue(0, 0, 1, 5, 0);
    expect_out("post_flush5", 0, 0, 0, 1, 32'h55);
    step();

    // 6: writeback coinciding with a dependent read
    issue(0, 0, 0, 0, 3);
    expect_out("issue3", 0, 0, 0, 0, 0);
    step();
    issue(1, 3, 0, 0, 0);
    wb(3, 32'hA5A5A5A5);
`ifdef REGFILE_BYPASS_EN
    expect_out("bypass3", 0, 1, 32'hA5A5A5A5, 0, 0);
`else
    expect_out("nobypass3", 1, 1, 32'h0, 0, 0);
`endif
    step();
    issue(1, 3, 0, 0, 0);
    expect_out("after_wb3", 0, 1, 32'hA5A5A5A5, 0, 0);
    step();

    // write to a register with nothing pending still lands, count stays 0
    wb(31, 32'h31313131);
    expect_out("wb31_idle", 0, 0, 0, 0, 0);
    step();
    issue(1, 31, 1, 20, 0);
    expect_out("read31", 0, 1, 32'h31313131, 1, 32'h0);
    step();

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
